// File: rtl/spi_slave_core_if.sv
// spi_slave_core_if: SPI pins, frame configuration and the local TX/RX handshakes
// of the SPI slave engine. The slave modport is the engine's view; the master
// modport is the view of whatever drives it (the SPI master pins plus local logic).
interface spi_slave_core_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  cpol;
   logic                  cpha;
   logic                  lsbfe;
   logic                  sclk;
   logic                  ss;
   logic                  mosi;
   logic                  miso;
   logic                  miso_oe;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  busy;
   logic                  frame_err;
   logic                  tx_underrun;
   logic                  rx_overrun;

   modport slave (
      input  cpol, cpha, lsbfe, sclk, ss, mosi, tx_data, tx_valid, rx_ready,
      output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err,
             tx_underrun, rx_overrun
   );

   modport master (
      output cpol, cpha, lsbfe, sclk, ss, mosi, tx_data, tx_valid, rx_ready,
      input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, frame_err,
             tx_underrun, rx_overrun
   );
endinterface

// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI slave engine oversampling sclk/ss/mosi in the PCLK domain.
// Optional feature: define SPI_SLAVE_RXOVR_EN to drop a completed word while the
// previous one is still unread and raise the sticky rx_overrun flag; without it the
// new word overwrites rx_data and rx_overrun is tied low.
//
// state  | meaning
// IDLE   | ss released, miso tristated, sclk edges ignored
// ACTIVE | selected; shifting frames, back-to-back while ss stays low
module spi_slave_core #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] TX_DEFAULT  = {DATA_WIDTH{1'b1}}
) (
   input logic             PCLK,
   input logic             PRESET,
   spi_slave_core_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
   logic                   ss_s, sclk_s, mosi_s, ss_d, sclk_d;
   logic                   sclk_rise, sclk_fall, ss_fall, ss_rise, lead, trail;
   logic                   cpol_l, cpha_l, lsbfe_l, cpha_e, lsbfe_e;
   logic                   start, stop, sample_ev, shift_ev, complete, load;
   logic                   tx_full, miso_q, frame_err_q, tx_underrun_q;
   logic                   rx_valid_q, rx_accept, rx_drop;
   logic [DATA_WIDTH-1:0]  tx_buf, tx_shift, rx_shift, rx_word, load_word, rx_data_q;
   logic [CNT_W-1:0]       bit_cnt;

   function automatic logic next_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                      input logic lsb);
      return lsb ? {1'b0, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], 1'b0};
   endfunction

   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ss_fall   = ~ss_s & ss_d;
   assign ss_rise   = ss_s & ~ss_d;
   assign lead      = cpol_l ? sclk_fall : sclk_rise;
   assign trail     = cpol_l ? sclk_rise : sclk_fall;

   // Frame start takes the live config pins; later reloads use the latched copy.
   assign cpha_e    = start ? bus.cpha : cpha_l;
   assign lsbfe_e   = start ? bus.lsbfe : lsbfe_l;
   assign complete  = sample_ev && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
   assign load      = start || complete;
   assign load_word = tx_full ? tx_buf : TX_DEFAULT;
   assign rx_word   = lsbfe_l ? {mosi_s, rx_shift[DATA_WIDTH-1:1]}
                              : {rx_shift[DATA_WIDTH-2:0], mosi_s};
   assign rx_accept = rx_valid_q && bus.rx_ready;

`ifdef SPI_SLAVE_RXOVR_EN
   logic rx_overrun_q;
   assign rx_drop = complete && rx_valid_q && !rx_accept;

   // Sticky overrun: set on a dropped word, cleared by the next accepted read.
   always_ff @(posedge PCLK) begin
      if (PRESET)         rx_overrun_q <= 1'b0;
      else if (rx_drop)   rx_overrun_q <= 1'b1;
      else if (rx_accept) rx_overrun_q <= 1'b0;
   end
   assign bus.rx_overrun = rx_overrun_q;
`else
   assign rx_drop        = 1'b0;
   assign bus.rx_overrun = 1'b0;
`endif

   // Input synchronizers plus one delayed copy for edge detection.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         ss_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_d      <= 1'b1;
         sclk_d    <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
         ss_d      <= ss_s;
         sclk_d    <= sclk_s;
      end
   end

   // FSM state register.
   always_ff @(posedge PCLK) begin
      if (PRESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and per-cycle frame strobes; ss release wins over a coincident sclk edge.
   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      stop      = 1'b0;
      sample_ev = 1'b0;
      shift_ev  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d = ACTIVE;
               start   = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_d = IDLE;
               stop    = 1'b1;
            end else begin
               sample_ev = cpha_l ? trail : lead;
               // cpha=0: the trailing edge after the last sample must not shift the reloaded word
               shift_ev  = cpha_l ? lead : (trail && (bit_cnt != '0));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Shifters, bit counter, TX buffer, RX holding register and status pulses.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         cpol_l        <= 1'b0;
         cpha_l        <= 1'b0;
         lsbfe_l       <= 1'b0;
         tx_full       <= 1'b0;
         tx_buf        <= '0;
         tx_shift      <= '0;
         rx_shift      <= '0;
         bit_cnt       <= '0;
         miso_q        <= 1'b0;
         frame_err_q   <= 1'b0;
         tx_underrun_q <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
      end else begin
         frame_err_q   <= 1'b0;
         tx_underrun_q <= 1'b0;
         if (start) begin
            cpol_l  <= bus.cpol;
            cpha_l  <= bus.cpha;
            lsbfe_l <= bus.lsbfe;
         end
         if (load && tx_full) begin
            tx_full <= 1'b0;
         end else if (bus.tx_valid && !tx_full) begin
            tx_full <= 1'b1;
            tx_buf  <= bus.tx_data;
         end
         if (load) begin
            tx_underrun_q <= !tx_full;
            if (!cpha_e) begin
               miso_q   <= next_bit(load_word, lsbfe_e);
               tx_shift <= shift_out(load_word, lsbfe_e);
            end else begin
               tx_shift <= load_word;
            end
         end else if (shift_ev) begin
            miso_q   <= next_bit(tx_shift, lsbfe_l);
            tx_shift <= shift_out(tx_shift, lsbfe_l);
         end
         if (stop) begin
            miso_q      <= 1'b0;
            frame_err_q <= (bit_cnt != '0);
            bit_cnt     <= '0;
         end else if (complete) begin
            bit_cnt <= '0;
         end else if (sample_ev) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
         if (sample_ev) rx_shift <= rx_word;
         if (complete && !rx_drop) begin
            rx_data_q  <= rx_word;
            rx_valid_q <= 1'b1;
         end else if (rx_accept) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   assign bus.miso        = miso_q;
   assign bus.miso_oe     = (state_q == ACTIVE);
   assign bus.busy        = (state_q == ACTIVE);
   assign bus.tx_ready    = !tx_full;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.tx_underrun = tx_underrun_q;
endmodule
